// File: rtl/adc_line_packer_if.sv
// rtl/adc_line_packer_if.sv - sample input and packed-line output bundle for adc_line_packer
interface adc_line_packer_if #(
    parameter int PORTS      = 32,
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]              S_DATA;
    logic                               S_VALID;
    logic                               S_SOL;
    logic [PORTS-1:0][DATA_WIDTH+4:0]   ODATA;
    logic                               ODAV;
    logic                               LINE_ERR;
    logic [15:0]                        LINE_CNT;

    modport master (
        output S_DATA, S_VALID, S_SOL,
        input  ODATA, ODAV, LINE_ERR, LINE_CNT
    );

    modport slave (
        input  S_DATA, S_VALID, S_SOL,
        output ODATA, ODAV, LINE_ERR, LINE_CNT
    );
endinterface

// File: rtl/adc_line_packer.sv
// rtl/adc_line_packer.sv - packs one line of tagged ADC samples into a double-buffered wide word
module adc_line_packer #(
    parameter int PORTS      = 32,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst,
    adc_line_packer_if.slave   bus
);
    localparam int SW = DATA_WIDTH + 5;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                   state_q, state_d;
    logic [5:0]               cnt_q, cnt_d;
    logic [7:0]               timer_q, timer_d;
    logic [PORTS-1:0][SW-1:0] fill_q, fill_d;
    logic [PORTS-1:0][SW-1:0] odata_q, odata_d;
    logic                     odav_q, odav_d;
    logic                     err_q, err_d;
    logic [15:0]              line_cnt_q, line_cnt_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        fill_d     = fill_q;
        odata_d    = odata_q;
        odav_d     = 1'b0;
        err_d      = 1'b0;
        line_cnt_d = line_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.S_VALID && bus.S_SOL) begin
                    fill_d[0] = {5'd0, bus.S_DATA};
                    cnt_d     = 6'd1;
                    timer_d   = 8'd0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (bus.S_VALID) begin
                    timer_d = 8'd0;
                    if (bus.S_SOL) begin
                        // Short line: drop what we have and restart on this sample
                        err_d     = 1'b1;
                        fill_d[0] = {5'd0, bus.S_DATA};
                        cnt_d     = 6'd1;
                    end else begin
                        fill_d[cnt_q[4:0]] = {cnt_q[4:0], bus.S_DATA};
                        if (cnt_q == 6'(PORTS - 1)) begin
                            // Publish including the sample written this cycle
                            odata_d    = fill_d;
                            odav_d     = 1'b1;
                            line_cnt_d = line_cnt_q + 16'd1;
                            cnt_d      = 6'd0;
                            state_d    = IDLE;
                        end else begin
                            cnt_d = cnt_q + 6'd1;
                        end
                    end
                end else if (timer_q == 8'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = 6'd0;
                    timer_d = 8'd0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
                timer_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            timer_q    <= 8'd0;
            odata_q    <= '0;
            odav_q     <= 1'b0;
            err_q      <= 1'b0;
            line_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            odata_q    <= odata_d;
            odav_q     <= odav_d;
            err_q      <= err_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    // Stale slots never escape: every slot is rewritten in order before a publish
    always_ff @(posedge clk) begin
        fill_q <= fill_d;
    end

    assign bus.ODATA    = odata_q;
    assign bus.ODAV     = odav_q;
    assign bus.LINE_ERR = err_q;
    assign bus.LINE_CNT = line_cnt_q;
endmodule

// File: tb/tb_adc_line_packer.sv
// tb/tb_adc_line_packer.sv - directed self-checking bench for adc_line_packer
module tb_adc_line_packer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adc_line_packer_if #(.PORTS(32), .DATA_WIDTH(16)) bus ();

    adc_line_packer #(.PORTS(32), .DATA_WIDTH(16), .TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int odav_n = 0;
    int err_n  = 0;
    int cyc    = 0;
    int odav_cyc[$];
    int o0, e0, n0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.ODAV) begin
            odav_n++;
            odav_cyc.push_back(cyc);
        end
        if (bus.LINE_ERR) err_n++;
        if (bus.ODAV || bus.LINE_ERR) check("odav_err_excl", 64'(bus.ODAV & bus.LINE_ERR), 64'd0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] d, input logic sol);
        bus.S_DATA  = d;
        bus.S_VALID = 1'b1;
        bus.S_SOL   = sol;
        tick(1);
        bus.S_VALID = 1'b0;
        bus.S_SOL   = 1'b0;
    endtask

    task automatic send_line(input logic [15:0] base, input logic [15:0] step, input int gap);
        for (int i = 0; i < 32; i++) begin
            if (i > 0 && gap > 0) tick(gap);
            send(16'(base + 16'(i) * step), i == 0);
        end
    endtask

    task automatic check_line(input string tag, input logic [15:0] base, input logic [15:0] step);
        logic [20:0] exp;
        for (int i = 0; i < 32; i++) begin
            exp = {5'(i), 16'(base + 16'(i) * step)};
            check(tag, 64'(bus.ODATA[i]), 64'(exp));
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.S_DATA  = '0;
        bus.S_VALID = 1'b0;
        bus.S_SOL   = 1'b0;
        tick(3);
        check("rst_odav", 64'(bus.ODAV), 64'd0);
        check("rst_err", 64'(bus.LINE_ERR), 64'd0);
        check("rst_cnt", 64'(bus.LINE_CNT), 64'd0);
        check("rst_odata0", 64'(bus.ODATA[0]), 64'd0);
        check("rst_odata31", 64'(bus.ODATA[31]), 64'd0);
        rst = 1'b0;
        tick(2);

        // Full line, consecutive samples
        o0 = odav_n; e0 = err_n;
        send_line(16'h0100, 16'd1, 0);
        check("l1_odav", 64'(bus.ODAV), 64'd1);
        check_line("l1_slot", 16'h0100, 16'd1);
        check("l1_cnt", 64'(bus.LINE_CNT), 64'd1);
        tick(1);
        check("l1_odav_drop", 64'(bus.ODAV), 64'd0);
        check("l1_pulses", 64'(odav_n - o0), 64'd1);
        check("l1_errs", 64'(err_n - e0), 64'd0);

        // Same line with 10-cycle gaps
        o0 = odav_n; e0 = err_n;
        send_line(16'h0100, 16'd1, 10);
        check("l2_odav", 64'(bus.ODAV), 64'd1);
        check_line("l2_slot", 16'h0100, 16'd1);
        check("l2_cnt", 64'(bus.LINE_CNT), 64'd2);
        tick(2);
        check("l2_pulses", 64'(odav_n - o0), 64'd1);
        check("l2_errs", 64'(err_n - e0), 64'd0);

        // Early SOL after 20 samples, then a full 0xAAAA line
        o0 = odav_n; e0 = err_n;
        for (int i = 0; i < 20; i++) send(16'h5555, i == 0);
        check("es_no_err_yet", 64'(bus.LINE_ERR), 64'd0);
        send(16'hAAAA, 1'b1);
        check("es_err", 64'(bus.LINE_ERR), 64'd1);
        check("es_odata_kept", 64'(bus.ODATA[5]), 64'({5'd5, 16'h0105}));
        check("es_cnt_kept", 64'(bus.LINE_CNT), 64'd2);
        for (int i = 1; i < 32; i++) send(16'hAAAA, 1'b0);
        check("es_odav", 64'(bus.ODAV), 64'd1);
        check_line("es_slot", 16'hAAAA, 16'd0);
        check("es_cnt", 64'(bus.LINE_CNT), 64'd3);
        tick(1);
        check("es_pulses", 64'(odav_n - o0), 64'd1);
        check("es_errs", 64'(err_n - e0), 64'd1);

        // Timeout after 10 samples, then stray non-SOL samples are ignored
        o0 = odav_n; e0 = err_n;
        for (int i = 0; i < 10; i++) send(16'h7700 + 16'(i), i == 0);
        tick(254);
        check("to_not_yet", 64'(bus.LINE_ERR), 64'd0);
        tick(1);
        check("to_err", 64'(bus.LINE_ERR), 64'd1);
        tick(1);
        check("to_err_drop", 64'(bus.LINE_ERR), 64'd0);
        for (int i = 0; i < 40; i++) send(16'h6600 + 16'(i), 1'b0);
        tick(2);
        check("to_no_odav", 64'(odav_n - o0), 64'd0);
        check("to_errs", 64'(err_n - e0), 64'd1);
        check("to_odata_kept", 64'(bus.ODATA[3]), 64'({5'd3, 16'hAAAA}));
        check("to_cnt", 64'(bus.LINE_CNT), 64'd3);

        // Back-to-back lines with zero gap
        o0 = odav_n; e0 = err_n; n0 = odav_cyc.size();
        send_line(16'h1000, 16'd1, 0);
        check("bb_odav_a", 64'(bus.ODAV), 64'd1);
        for (int i = 0; i < 32; i++) begin
            send(16'h2000 + 16'(i), i == 0);
            if (i == 16) begin
                check("bb_hold0", 64'(bus.ODATA[0]), 64'({5'd0, 16'h1000}));
                check("bb_hold31", 64'(bus.ODATA[31]), 64'({5'd31, 16'h101F}));
            end
        end
        check("bb_odav_b", 64'(bus.ODAV), 64'd1);
        check_line("bb_slot", 16'h2000, 16'd1);
        check("bb_cnt", 64'(bus.LINE_CNT), 64'd5);
        tick(1);
        check("bb_pulses", 64'(odav_n - o0), 64'd2);
        check("bb_errs", 64'(err_n - e0), 64'd0);
        if (odav_cyc.size() >= n0 + 2)
            check("bb_spacing", 64'(odav_cyc[n0+1] - odav_cyc[n0]), 64'd32);
        else
            check("bb_spacing_missing", 64'(odav_cyc.size()), 64'(n0 + 2));

        // Reset during a partial line
        o0 = odav_n; e0 = err_n;
        for (int i = 0; i < 15; i++) send(16'h3300 + 16'(i), i == 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rs_cnt", 64'(bus.LINE_CNT), 64'd0);
        check("rs_odata", 64'(bus.ODATA[0]), 64'd0);
        send_line(16'h3000, 16'd1, 0);
        check("rs_odav", 64'(bus.ODAV), 64'd1);
        check("rs_slot7", 64'(bus.ODATA[7]), 64'({5'd7, 16'h3007}));
        check("rs_cnt1", 64'(bus.LINE_CNT), 64'd1);
        tick(1);
        check("rs_pulses", 64'(odav_n - o0), 64'd1);
        check("rs_errs", 64'(err_n - e0), 64'd0);

        // Line counter wrap
        @(negedge clk);
        force dut.line_cnt_q = 16'hFFFF;
        release dut.line_cnt_q;
        #1;
        check("wr_preload", 64'(bus.LINE_CNT), 64'hFFFF);
        tick(1);
        e0 = err_n;
        send_line(16'h4000, 16'd3, 0);
        check("wr_odav", 64'(bus.ODAV), 64'd1);
        check("wr_cnt", 64'(bus.LINE_CNT), 64'd0);
        check("wr_slot31", 64'(bus.ODATA[31]), 64'({5'd31, 16'h405D}));
        tick(1);
        check("wr_errs", 64'(err_n - e0), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
